// File: rtl/fp_result_collector.sv
// fp_result_collector: captures fp_reciprocal_pipeline result beats into a tagged
// FIFO, presents them on a valid/ready read port and issues launch credit
// upstream so that every result in flight has a guaranteed slot.
// Optional feature macro: FP_COLLECTOR_STICKY_FLAGS_EN (sticky status_flags register).
module fp_result_collector #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    output logic             issue_ready,
    input  logic [31:0]      out,
    input  logic             overflow,
    input  logic             underflow,
    input  logic             inexact,
    input  logic             invalid_operation,
    input  logic             division_by_zero,
    input  logic             valid_data_out,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      rd_data,
    output logic [4:0]       rd_flags,
    output logic [TAG_W-1:0] rd_tag,
    output logic [4:0]       status_flags,
    input  logic             flags_clr,
    output logic             drop_err,
    output logic             protocol_err
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DepthC  = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DepthCx = (CNT_W + 1)'(DEPTH);

    logic [31:0]      data_mem [DEPTH];
    logic [4:0]       flag_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [TAG_W-1:0] tag_cnt_q;
    logic             drop_err_q, protocol_err_q;

    logic [4:0]       cap_flags;
    logic [CNT_W:0]   occupancy;
    logic             full, pop, push, issue_ok;

    assign cap_flags = {invalid_operation, division_by_zero, overflow, underflow, inexact};

    // Credit: results in flight plus results held must fit in the FIFO.
    assign occupancy   = {1'b0, inflight_q} + {1'b0, count_q};
    assign issue_ready = occupancy < DepthCx;
    assign issue_ok    = issue && issue_ready;

    assign rd_valid = count_q != '0;
    assign full     = count_q == DepthC;
    assign pop      = rd_valid && rd_ready;
    // A full FIFO still takes a beat when the head leaves in the same cycle.
    assign push     = valid_data_out && (!full || pop);

    // Head outputs are zero while empty so nothing unwritten ever leaks out.
    assign rd_data  = rd_valid ? data_mem[rd_ptr_q] : '0;
    assign rd_flags = rd_valid ? flag_mem[rd_ptr_q] : '0;
    assign rd_tag   = rd_valid ? tag_mem[rd_ptr_q]  : '0;

    assign drop_err     = drop_err_q;
    assign protocol_err = protocol_err_q;

    // Next-state for occupancy and in-flight counters.
    always_comb begin
        count_d    = count_q;
        inflight_d = inflight_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Results arriving after a reset are not owed to any launch, hence the floor at 0.
        if (issue_ok && !valid_data_out) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!issue_ok && valid_data_out && inflight_q != '0) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // Control state: pointers, counters, tag and sticky error bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            inflight_q     <= '0;
            tag_cnt_q      <= '0;
            drop_err_q     <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            if (push) begin
                wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
                tag_cnt_q <= tag_cnt_q + TAG_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (valid_data_out && !push) begin
                drop_err_q <= 1'b1;
            end
            if (issue && !issue_ready) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

    // FIFO storage; only ever read at occupied slots, so no reset needed.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            data_mem[wr_ptr_q] <= out;
            flag_mem[wr_ptr_q] <= cap_flags;
            tag_mem[wr_ptr_q]  <= tag_cnt_q;
        end
    end

`ifdef FP_COLLECTOR_STICKY_FLAGS_EN
    logic [4:0] status_q;

    // Sticky flag accumulator; a clear coinciding with a push keeps only the new flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
        end else if (flags_clr) begin
            status_q <= push ? cap_flags : 5'b0;
        end else if (push) begin
            status_q <= status_q | cap_flags;
        end
    end

    assign status_flags = status_q;
`else
    logic unused_flags_clr;
    assign unused_flags_clr = flags_clr;
    assign status_flags     = '0;
`endif

endmodule

// File: tb/tb_fp_result_collector.sv
// Self-checking bench for fp_result_collector: vector table plus hand-written
// sequences, with a queue scoreboard holding the expected FIFO contents.
module tb_fp_result_collector;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, issue, valid_data_out, rd_ready, flags_clr;
    logic        overflow, underflow, inexact, invalid_operation, division_by_zero;
    logic [31:0] out;
    logic        issue_ready, rd_valid, drop_err, protocol_err;
    logic [31:0] rd_data;
    logic [4:0]  rd_flags, status_flags;
    logic [3:0]  rd_tag;

    fp_result_collector #(.DEPTH(DEPTH), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .issue(issue), .issue_ready(issue_ready), .out(out),
        .overflow(overflow), .underflow(underflow), .inexact(inexact),
        .invalid_operation(invalid_operation), .division_by_zero(division_by_zero),
        .valid_data_out(valid_data_out), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_flags(rd_flags), .rd_tag(rd_tag),
        .status_flags(status_flags), .flags_clr(flags_clr), .drop_err(drop_err),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  f;
        logic [3:0]  t;
    } ent_t;

    ent_t       sb[$];
    logic [3:0] m_tag;
    int         m_inflight;
    logic       m_drop, m_perr;
    logic [4:0] m_status;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue = 0; valid_data_out = 0; rd_ready = 0; flags_clr = 0; out = '0;
        {invalid_operation, division_by_zero, overflow, underflow, inexact} = 5'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        sb.delete();
        m_tag = 0; m_inflight = 0; m_drop = 0; m_perr = 0; m_status = 0;
    endtask

    // Check outputs against the model, drive one cycle of inputs, update the model.
    task automatic step(input logic iss, input logic vld, input logic [31:0] d,
                        input logic [4:0] f, input logic rdy, input logic clr);
        logic pop_m, ready_m, iss_ok, push_ok;
        ready_m = (m_inflight + sb.size()) < DEPTH;
        chk("issue_ready", 32'(issue_ready), 32'(ready_m));
        chk("rd_valid", 32'(rd_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("rd_data", rd_data, sb[0].d);
            chk("rd_flags", 32'(rd_flags), 32'(sb[0].f));
            chk("rd_tag", 32'(rd_tag), 32'(sb[0].t));
        end
        chk("drop_err", 32'(drop_err), 32'(m_drop));
        chk("protocol_err", 32'(protocol_err), 32'(m_perr));
        chk("status_flags", 32'(status_flags), 32'(m_status));

        issue = iss; valid_data_out = vld; out = d; rd_ready = rdy; flags_clr = clr;
        {invalid_operation, division_by_zero, overflow, underflow, inexact} = f;

        pop_m   = (sb.size() != 0) && rdy;
        iss_ok  = iss && ready_m;
        push_ok = vld && ((sb.size() < DEPTH) || pop_m);
        if (iss && !ready_m) m_perr = 1;
        if (iss_ok && !vld) m_inflight++;
        else if (!iss_ok && vld && m_inflight > 0) m_inflight--;
        if (pop_m) void'(sb.pop_front());
        if (push_ok) begin
            sb.push_back('{d: d, f: f, t: m_tag});
            m_tag = m_tag + 4'd1;
        end else if (vld) begin
            m_drop = 1;
        end
`ifdef FP_COLLECTOR_STICKY_FLAGS_EN
        if (clr) m_status = push_ok ? f : 5'b0;
        else if (push_ok) m_status = m_status | f;
`endif
        @(posedge clk); #1;
        idle_inputs();
    endtask

    typedef struct {
        logic        iss, vld;
        logic [31:0] d;
        logic [4:0]  f;
        logic        rdy;
        logic        exp_rv, exp_ir;
        logic [31:0] exp_data;
        logic [3:0]  exp_tag;
    } vec_t;

    vec_t       vecs[9];
    logic [3:0] got_tags[$];
    logic [4:0] exp_st;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Expected rd_valid/issue_ready/head are the state seen before each row is applied.
        vecs[0] = '{0, 0, 32'h0,        5'b00000, 0, 0, 1, 32'h0,        4'd0};
        vecs[1] = '{0, 1, 32'h3F800000, 5'b00000, 0, 0, 1, 32'h0,        4'd0};
        vecs[2] = '{0, 0, 32'h0,        5'b00000, 1, 1, 1, 32'h3F800000, 4'd0};
        vecs[3] = '{0, 0, 32'h0,        5'b00000, 0, 0, 1, 32'h0,        4'd0};
        vecs[4] = '{1, 0, 32'h0,        5'b00000, 0, 0, 1, 32'h0,        4'd0};
        vecs[5] = '{1, 1, 32'h40000000, 5'b00001, 0, 0, 1, 32'h0,        4'd0};
        vecs[6] = '{0, 1, 32'h3F000000, 5'b00000, 1, 1, 1, 32'h40000000, 4'd1};
        vecs[7] = '{0, 0, 32'h0,        5'b00000, 1, 1, 1, 32'h3F000000, 4'd2};
        vecs[8] = '{0, 0, 32'h0,        5'b00000, 0, 0, 1, 32'h0,        4'd0};

        do_reset();
        chk("reset rd_data", rd_data, 32'h0);
        chk("reset rd_tag", 32'(rd_tag), 32'h0);
        chk("reset rd_flags", 32'(rd_flags), 32'h0);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_rv));
            chk($sformatf("vec%0d issue_ready", i), 32'(issue_ready), 32'(vecs[i].exp_ir));
            if (vecs[i].exp_rv) begin
                chk($sformatf("vec%0d data", i), rd_data, vecs[i].exp_data);
                chk($sformatf("vec%0d tag", i), 32'(rd_tag), 32'(vecs[i].exp_tag));
            end
            step(vecs[i].iss, vecs[i].vld, vecs[i].d, vecs[i].f, vecs[i].rdy, 1'b0);
        end

        // Credit exhaustion, protocol error, in-order tagged drain.
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);
        chk("credit exhausted", 32'(issue_ready), 32'h0);
        step(1, 0, 0, 0, 0, 0);
        chk("protocol_err set", 32'(protocol_err), 32'h1);
        for (int i = 0; i < 8; i++) step(0, 1, 32'h3F000000 + 32'(i), 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk("drain data", rd_data, 32'h3F000000 + 32'(i));
            chk("drain tag", 32'(rd_tag), 32'(i));
            step(0, 0, 0, 0, 1, 0);
        end
        chk("drained", 32'(rd_valid), 32'h0);

        // Full FIFO: drop without pop, accept with simultaneous pop.
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 1, 32'h3F100000 + 32'(i), 0, 0, 0);
        step(0, 1, 32'hAAAA0000, 0, 0, 0);
        chk("drop_err set", 32'(drop_err), 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk("after drop data", rd_data, 32'h3F100000 + 32'(i));
            step(0, 0, 0, 0, 1, 0);
        end
        for (int i = 0; i < 8; i++) step(0, 1, 32'h3F200000 + 32'(i), 0, 0, 0);
        chk("full head", rd_data, 32'h3F200000);
        step(0, 1, 32'h3F2000FF, 0, 1, 0);
        chk("still full", 32'(issue_ready), 32'h0);
        for (int i = 1; i < 9; i++) begin
            chk("pop-push data", rd_data, (i == 8) ? 32'h3F2000FF : 32'h3F200000 + 32'(i));
            step(0, 0, 0, 0, 1, 0);
        end
        chk("no extra drop", 32'(rd_valid), 32'h0);

        // Sticky flag accumulation and clear-with-push.
        do_reset();
        step(0, 1, 32'h7F800000, 5'b01000, 0, 0);
        step(0, 1, 32'h3F800000, 5'b00001, 0, 0);
        chk("div0 head flags", 32'(rd_flags), 32'h08);
`ifdef FP_COLLECTOR_STICKY_FLAGS_EN
        exp_st = 5'b01001;
`else
        exp_st = 5'b00000;
`endif
        chk("status accumulate", 32'(status_flags), 32'(exp_st));
        step(0, 1, 32'h3F800000, 5'b00100, 0, 1);
`ifdef FP_COLLECTOR_STICKY_FLAGS_EN
        exp_st = 5'b00100;
`else
        exp_st = 5'b00000;
`endif
        chk("status clear+push", 32'(status_flags), 32'(exp_st));

        // Stream 20 results under random back-pressure; tags must wrap 0..15, 0..3.
        do_reset();
        got_tags.delete();
        begin
            int sent = 0;
            for (int cyc = 0; cyc < 300 && (sent < 20 || sb.size() != 0); cyc++) begin
                logic rdy, vld;
                rdy = (sent < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
                vld = (sent < 20) && (sb.size() < 6);
                if (rd_valid && rdy) got_tags.push_back(rd_tag);
                step(0, vld, 32'h41000000 + 32'(sent), 0, rdy, 0);
                if (vld) sent++;
            end
        end
        chk("stream count", 32'(got_tags.size()), 32'd20);
        for (int i = 0; i < got_tags.size() && i < 20; i++)
            chk("stream tag", 32'(got_tags[i]), 32'(i % 16));

        // Reset mid-operation flushes everything.
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 32'h3E000000 + 32'(i), 5'b00010, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
        chk("pre-rst credit", 32'(issue_ready), 32'h0);
        step(1, 0, 0, 0, 0, 0);
        chk("pre-rst perr", 32'(protocol_err), 32'h1);
        do_reset();
        chk("rst rd_valid", 32'(rd_valid), 32'h0);
        chk("rst issue_ready", 32'(issue_ready), 32'h1);
        chk("rst protocol_err", 32'(protocol_err), 32'h0);
        chk("rst drop_err", 32'(drop_err), 32'h0);
        chk("rst status", 32'(status_flags), 32'h0);
        step(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_result_collector.md
# fp_result_collector

Output-side companion to `fp_reciprocal_pipeline`. It captures every `valid_data_out` beat (result word plus five exception flags) into a tagged FIFO and presents results on a valid/ready read port. The pipeline has no stall input, so the block also issues credit to the upstream operand source: a launch is permitted only when a FIFO slot is guaranteed for its result. It sits between the reciprocal pipeline and any consumer that can back-pressure.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries and maximum results in flight; power of 2, ≥2.
- `TAG_W`, 4: width of the capture sequence tag.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `issue`  in  1  upstream launched an operand this cycle (same signal as the pipeline's `valid_data_in`)
- `issue_ready`  out  1  a launch this cycle is permitted
- `out`  in  32  pipeline result word
- `overflow`, `underflow`, `inexact`, `invalid_operation`, `division_by_zero`  in  1 each  pipeline flags
- `valid_data_out`  in  1  pipeline result valid; single-cycle beat, no back-pressure
- `rd_valid`  out  1  head entry available
- `rd_ready`  in  1  consumer accepts the head entry
- `rd_data`  out  32  head result word
- `rd_flags`  out  5  head flags `{invalid_operation, division_by_zero, overflow, underflow, inexact}` (bit 4..0)
- `rd_tag`  out  TAG_W  head capture sequence number
- `status_flags`  out  5  sticky OR of captured flags, same bit order
- `flags_clr`  in  1  clear `status_flags`
- `drop_err`  out  1  sticky: a result was lost because the FIFO was full
- `protocol_err`  out  1  sticky: `issue` was asserted while `issue_ready` was low

## Operation
- `inflight` counter, width $clog2(DEPTH)+1:
  - +1 on an accepted `issue`.
  - −1 on `valid_data_out`; saturates at 0.
  - No change when both events occur in the same cycle.
- `count` is the FIFO occupancy. `issue_ready = (inflight + count) < DEPTH`. It is combinational from registers only and does not depend on `issue`.
- Issue while `issue_ready` = 0:
  - Not counted.
  - `protocol_err` sets.
- Push on `valid_data_out`. The push is accepted if `count < DEPTH`, or if `count == DEPTH` and a pop occurs in the same cycle.
  - Otherwise the result is discarded and `drop_err` sets.
  - The tag counter does not advance on a discarded result.
- Each accepted push stores {`out`, flags, `tag_cnt`}, then increments `tag_cnt` mod 2^TAG_W.
- Pop occurs when `rd_valid && rd_ready`. `rd_*` outputs are stable while `rd_valid` is high and `rd_ready` is low.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally. `count` distinguishes full from empty.
- Sticky error bits (`drop_err`, `protocol_err`) clear only on `rst`.

## Timing
- Reset values: `issue_ready` = 1, `rd_valid` = 0, `rd_data` = 0, `rd_flags` = 0, `rd_tag` = 0, `status_flags` = 0, `drop_err` = 0, `protocol_err` = 0. Internal `inflight`, `count`, pointers and `tag_cnt` all reset to 0.
- Capture latency: a beat sampled at edge N gives `rd_valid` = 1 after edge N, i.e. visible in cycle N+1, when the FIFO was empty. There is no fall-through within the same cycle.
- Pop at edge N: the next entry is presented in cycle N+1. Back-to-back pops sustain one entry per cycle.
- `issue_ready` reflects issues, pushes and pops from the previous edge. An issue and a result beat in the same cycle leave `inflight` unchanged.
- `rst` mid-operation flushes the FIFO and clears all counters at that edge. Results still inside the pipeline that arrive after reset are:
  - Captured if space exists.
  - Not counted against `inflight`, because of the saturation at 0.

## Configuration
- `FP_COLLECTOR_STICKY_FLAGS_EN` defined:
  - `status_flags` is the register `status_flags | captured_flags` on each accepted push.
  - `flags_clr` zeroes it.
  - If a clear and a push occur in the same cycle, the register loads only the new push's flags.
- Not defined:
  - `status_flags` is tied to 0.
  - `flags_clr` is ignored.
  - No sticky-flag register is synthesised.
  - `drop_err` and `protocol_err` are unaffected.

## Test plan
- Reset, then one beat `out`=0x3F800000 with all flags 0 → `rd_valid` in the next cycle, `rd_data`=0x3F800000, `rd_flags`=0, `rd_tag`=0; a pop returns `rd_valid` to 0.
- 8 issues with `rd_ready`=0 → `issue_ready` falls after the 8th; a 9th issue sets `protocol_err`. 8 beats 0x3F000000…0x3F000007 → popped in order with tags 0..7.
- FIFO full plus one beat with `rd_ready`=0 → `drop_err`=1, contents unchanged. FIFO full plus a beat with `rd_ready`=1 in the same cycle → both accepted, `count` stays 8.
- Beat with `division_by_zero`=1 (`out`=0x7F800000), then a beat with `inexact`=1 → `status_flags`=5'b01001. Assert `flags_clr` together with a beat carrying `overflow` → `status_flags`=5'b00100. With the macro undefined, `status_flags` stays 0.
- Stream 20 results with `rd_ready` toggling pseudo-randomly → tags run 0..15 then 0..3, with no loss and no duplicates.
- Assert `rst` with 3 entries queued → the next cycle shows `rd_valid`=0 and `issue_ready`=1, and all sticky bits are 0.
